cr_prefix_attach_fetch_seq: RTL and testbench

Sequencer that drives one prefix fetch through the prefix memory/CRC-check datapath.
- Accepts a prefix number from the prefix-attach front end.
- Issues the PHD CRC load, then paces PHD word reads against downstream credit.
- Consumes the PHD CRC check result, then repeats the load/stream/check sequence for PFD.
- Returns a single completion status.
- Sits between the request queue and the prefix memory controller, replacing ad-hoc strobe generation.

---
 rtl/cr_prefix_attach_fetch_seq_if.sv | 49 ++++
 rtl/cr_prefix_attach_fetch_seq.sv | 183 ++++++++++++++++++
 tb/tb_cr_prefix_attach_fetch_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_prefix_attach_fetch_seq_if.sv
// Handshake and strobe bundle between the prefix-attach front end, the prefix
// memory/CRC-check datapath and the fetch sequencer.
interface cr_prefix_attach_fetch_seq_if;
  localparam int unsigned PN_W   = 6;
  localparam int unsigned STAT_W = 4;

  logic              req_valid;
  logic [PN_W-1:0]   req_prefix_num;
  logic              req_ready;
  logic              prefix_valid;
  logic [PN_W-1:0]   prefix_num;
  logic              ld_phd_crc_addr;
  logic              ld_pfd_crc_addr;
  logic              inc_phd_addr;
  logic              inc_pfd_addr;
  logic              out_ready;
  logic              phd_check_valid;
  logic              phd_crc_error;
  logic              pfd_check_valid;
  logic              pfd_crc_error;
  logic              phd_check_valid_ack;
  logic              pfd_check_valid_ack;
  logic              done_valid;
  logic [STAT_W-1:0] done_status;
  logic              done_ready;
  logic              busy;

  // Environment side: issues requests, models the datapath, consumes status.
  modport master (
    output req_valid, req_prefix_num, out_ready,
           phd_check_valid, phd_crc_error, pfd_check_valid, pfd_crc_error,
           done_ready,
    input  req_ready, prefix_valid, prefix_num,
           ld_phd_crc_addr, ld_pfd_crc_addr, inc_phd_addr, inc_pfd_addr,
           phd_check_valid_ack, pfd_check_valid_ack,
           done_valid, done_status, busy
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_prefix_num, out_ready,
           phd_check_valid, phd_crc_error, pfd_check_valid, pfd_crc_error,
           done_ready,
    output req_ready, prefix_valid, prefix_num,
           ld_phd_crc_addr, ld_pfd_crc_addr, inc_phd_addr, inc_pfd_addr,
           phd_check_valid_ack, pfd_check_valid_ack,
           done_valid, done_status, busy
  );
endinterface

// File: rtl/cr_prefix_attach_fetch_seq.sv
// Prefix fetch sequencer: PHD load/stream/check, then PFD load/stream/check,
// then one completion status held until consumed.
module cr_prefix_attach_fetch_seq #(
  parameter int unsigned PHD_WORDS   = 8,
  parameter int unsigned PFD_WORDS   = 64,
  parameter int unsigned CHK_TIMEOUT = 255
) (
  input logic                         clk,
  input logic                         rst_n,
  cr_prefix_attach_fetch_seq_if.slave bus
);
  localparam int unsigned WCNT_W = 7;
  localparam int unsigned TCNT_W = 8;

  localparam logic [WCNT_W-1:0] PHD_LAST = WCNT_W'(PHD_WORDS - 1);
  localparam logic [WCNT_W-1:0] PFD_LAST = WCNT_W'(PFD_WORDS - 1);
  localparam logic [TCNT_W-1:0] TMO_LAST = TCNT_W'(CHK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, PHD_LD, PHD_WAIT, PHD_STRM, PHD_CHK,
    PFD_LD, PFD_WAIT, PFD_STRM, PFD_CHK, DONE
  } state_t;

  state_t              state;
  logic [WCNT_W-1:0]   word_cnt;
  logic [TCNT_W-1:0]   tmo_cnt;
  logic                wait_cnt;

  // Word advances follow downstream credit within the cycle it is offered.
  assign bus.inc_phd_addr = (state == PHD_STRM) && bus.out_ready;
  assign bus.inc_pfd_addr = (state == PFD_STRM) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                   <= IDLE;
      word_cnt                <= '0;
      tmo_cnt                 <= '0;
      wait_cnt                <= 1'b0;
      bus.req_ready           <= 1'b1;
      bus.prefix_valid        <= 1'b0;
      bus.prefix_num          <= '0;
      bus.ld_phd_crc_addr     <= 1'b0;
      bus.ld_pfd_crc_addr     <= 1'b0;
      bus.phd_check_valid_ack <= 1'b0;
      bus.pfd_check_valid_ack <= 1'b0;
      bus.done_valid          <= 1'b0;
      bus.done_status         <= '0;
      bus.busy                <= 1'b0;
    end else begin
      bus.ld_phd_crc_addr     <= 1'b0;
      bus.ld_pfd_crc_addr     <= 1'b0;
      bus.phd_check_valid_ack <= 1'b0;
      bus.pfd_check_valid_ack <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.prefix_num <= bus.req_prefix_num;
            bus.req_ready  <= 1'b0;
            bus.busy       <= 1'b1;
            // Prefix 0 is illegal: report it without touching memory.
            if (bus.req_prefix_num == '0) begin
              bus.done_status <= 4'b1000;
              bus.done_valid  <= 1'b1;
              state           <= DONE;
            end else begin
              bus.done_status     <= '0;
              bus.prefix_valid    <= 1'b1;
              bus.ld_phd_crc_addr <= 1'b1;
              state               <= PHD_LD;
            end
          end
        end

        PHD_LD: begin
          wait_cnt <= 1'b0;
          state    <= PHD_WAIT;
        end

        // Two cycles for the controller's load-to-CRC-latch pipeline.
        PHD_WAIT: begin
          if (wait_cnt) begin
            wait_cnt <= 1'b0;
            word_cnt <= '0;
            state    <= PHD_STRM;
          end else begin
            wait_cnt <= 1'b1;
          end
        end

        PHD_STRM: begin
          if (bus.out_ready) begin
            if (word_cnt == PHD_LAST) begin
              word_cnt <= '0;
              tmo_cnt  <= '0;
              state    <= PHD_CHK;
            end else begin
              word_cnt <= word_cnt + WCNT_W'(1);
            end
          end
        end

        PHD_CHK: begin
          if (bus.phd_check_valid) begin
            bus.done_status[0]      <= bus.phd_crc_error;
            bus.phd_check_valid_ack <= 1'b1;
            bus.ld_pfd_crc_addr     <= 1'b1;
            state                   <= PFD_LD;
          end else if (tmo_cnt == TMO_LAST) begin
            bus.done_status[2]      <= 1'b1;
            bus.phd_check_valid_ack <= 1'b1;
            bus.prefix_valid        <= 1'b0;
            bus.done_valid          <= 1'b1;
            state                   <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TCNT_W'(1);
          end
        end

        PFD_LD: begin
          wait_cnt <= 1'b0;
          state    <= PFD_WAIT;
        end

        PFD_WAIT: begin
          if (wait_cnt) begin
            wait_cnt <= 1'b0;
            word_cnt <= '0;
            state    <= PFD_STRM;
          end else begin
            wait_cnt <= 1'b1;
          end
        end

        PFD_STRM: begin
          if (bus.out_ready) begin
            if (word_cnt == PFD_LAST) begin
              word_cnt <= '0;
              tmo_cnt  <= '0;
              state    <= PFD_CHK;
            end else begin
              word_cnt <= word_cnt + WCNT_W'(1);
            end
          end
        end

        // Either outcome ends the fetch; only the status bit differs.
        PFD_CHK: begin
          if (bus.pfd_check_valid || (tmo_cnt == TMO_LAST)) begin
            if (bus.pfd_check_valid) begin
              bus.done_status[1] <= bus.pfd_crc_error;
            end else begin
              bus.done_status[2] <= 1'b1;
            end
            bus.pfd_check_valid_ack <= 1'b1;
            bus.prefix_valid        <= 1'b0;
            bus.done_valid          <= 1'b1;
            state                   <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TCNT_W'(1);
          end
        end

        DONE: begin
          if (bus.done_ready) begin
            bus.done_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.busy       <= 1'b0;
            state          <= IDLE;
          end
        end

        default: begin
          bus.prefix_valid <= 1'b0;
          bus.done_valid   <= 1'b0;
          bus.req_ready    <= 1'b1;
          bus.busy         <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cr_prefix_attach_fetch_seq.sv
// Self-checking bench for cr_prefix_attach_fetch_seq: scripted and random
// fetches compared against cycle/count expectations derived from the sequence rules.
module tb_cr_prefix_attach_fetch_seq;
  localparam int PHD_W = 8;
  localparam int PFD_W = 64;
  localparam int TMO   = 10;
  localparam int MAXC  = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cr_prefix_attach_fetch_seq_if bus();

  cr_prefix_attach_fetch_seq #(
    .PHD_WORDS(PHD_W), .PFD_WORDS(PFD_W), .CHK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Per-fetch observations, cycle numbers relative to the accept cycle (0).
  int n_ld_phd, c_ld_phd, n_ld_pfd, c_ld_pfd, n_inc_phd, n_inc_pfd;
  int c_inc_first, c_inc_last, n_bad_inc, n_ack_phd, c_ack_phd, n_ack_pfd;
  int n_ld_both, n_pv, c_done, n_done_hi, n_stat_chg, phd_start, pfd_start;
  logic [3:0] st_done;
  logic [5:0] pnum_seen;
  bit acc_rdy, idle_ok, rst_ok, run_to;

  function automatic bit rdy_pat(input int c);
    return (c % 4 == 0) || (c % 4 == 3);
  endfunction

  function automatic bit tmo_hit(input int d);
    return (d < 0) || (d >= TMO);
  endfunction

  function automatic logic [3:0] exp_status(input logic [5:0] pn, input int pd,
                                            input int fd, input bit pe, input bit fe);
    if (pn == 6'd0) return 4'b1000;
    if (tmo_hit(pd)) return 4'b0100;
    if (tmo_hit(fd)) return {2'b01, 1'b0, pe};
    return {2'b00, fe, pe};
  endfunction

  function automatic int exp_done(input logic [5:0] pn, input int pd, input int fd,
                                  input int ps, input int fs);
    if (pn == 6'd0) return 1;
    if (tmo_hit(pd)) return ps + TMO;
    if (tmo_hit(fd)) return fs + TMO;
    return fs + fd + 1;
  endfunction

  // Drives one fetch from the current IDLE cycle to the IDLE cycle after DONE.
  // pd/fd: check_valid delay after CHK entry (-1 = never); rmode 0 ready=1,
  // 1 random, 2 pattern 1,0,0,1; hold: cycles done_ready is withheld;
  // rst_at: pulse reset after that many PFD increments (-1 = never).
  task automatic run_fetch(input logic [5:0] pn, input int pd, input int fd,
                           input bit pe, input bit fe, input int rmode,
                           input int hold, input int rst_at);
    bit fin, rdy_given, phd_acked, pfd_acked;
    n_ld_phd = 0; c_ld_phd = -1; n_ld_pfd = 0; c_ld_pfd = -1; n_inc_phd = 0;
    n_inc_pfd = 0; c_inc_first = -1; c_inc_last = -1; n_bad_inc = 0;
    n_ack_phd = 0; c_ack_phd = -1; n_ack_pfd = 0; n_ld_both = 0; n_pv = 0;
    c_done = -1; n_done_hi = 0; n_stat_chg = 0; phd_start = -1; pfd_start = -1;
    st_done = 'x; pnum_seen = 'x; idle_ok = 0; rst_ok = 0; run_to = 0;
    fin = 0; rdy_given = 0; phd_acked = 0; pfd_acked = 0;
    acc_rdy = bus.req_ready;
    bus.req_valid = 1'b1; bus.req_prefix_num = pn; bus.done_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_prefix_num = 6'($urandom);
    for (int cyc = 1; cyc <= MAXC && !fin; cyc++) begin
      if (rdy_given) begin
        idle_ok = !bus.done_valid && bus.req_ready && !bus.busy;
        bus.done_ready = 1'b0;
        fin = 1;
      end else begin
        if (cyc == 1) pnum_seen = bus.prefix_num;
        if (bus.ld_phd_crc_addr) begin n_ld_phd++; if (c_ld_phd < 0) c_ld_phd = cyc; end
        if (bus.ld_pfd_crc_addr) begin n_ld_pfd++; if (c_ld_pfd < 0) c_ld_pfd = cyc; end
        if (bus.ld_phd_crc_addr && bus.ld_pfd_crc_addr) n_ld_both++;
        if (bus.phd_check_valid_ack) begin n_ack_phd++; phd_acked = 1; if (c_ack_phd < 0) c_ack_phd = cyc; end
        if (bus.pfd_check_valid_ack) begin n_ack_pfd++; pfd_acked = 1; end
        if (bus.prefix_valid) n_pv++;
        if (bus.done_valid) begin
          n_done_hi++;
          if (c_done < 0) begin c_done = cyc; st_done = bus.done_status; end
          else if (bus.done_status !== st_done) n_stat_chg++;
          rdy_given = (n_done_hi > hold);
          bus.done_ready = rdy_given;
        end else begin
          bus.done_ready = 1'($urandom);  // must be ignored outside DONE
        end
        bus.out_ready = (rmode == 0) ? 1'b1 : (rmode == 2) ? rdy_pat(cyc) : 1'($urandom);
        bus.phd_check_valid = (phd_start >= 0) && (pd >= 0) && (cyc >= phd_start + pd) && !phd_acked;
        bus.phd_crc_error   = bus.phd_check_valid ? pe : 1'($urandom);
        bus.pfd_check_valid = (pfd_start >= 0) && (fd >= 0) && (cyc >= pfd_start + fd) && !pfd_acked;
        bus.pfd_crc_error   = bus.pfd_check_valid ? fe : 1'($urandom);
        #1;
        if (bus.inc_phd_addr) begin
          n_inc_phd++;
          if (!bus.out_ready) n_bad_inc++;
          if (c_inc_first < 0) c_inc_first = cyc;
          c_inc_last = cyc;
          if (n_inc_phd == PHD_W) phd_start = cyc + 1;
        end
        if (bus.inc_pfd_addr) begin
          n_inc_pfd++;
          if (!bus.out_ready) n_bad_inc++;
          if (n_inc_pfd == PFD_W) pfd_start = cyc + 1;
        end
        if (rst_at >= 0 && n_inc_pfd == rst_at) begin
          rst_n = 1'b0; bus.out_ready = 1'b1;
          bus.phd_check_valid = 1'b0; bus.pfd_check_valid = 1'b0; bus.done_ready = 1'b0;
          @(posedge clk); #1;
          rst_ok = !bus.busy && bus.req_ready && !bus.done_valid && !bus.prefix_valid &&
                   ({bus.ld_phd_crc_addr, bus.ld_pfd_crc_addr, bus.inc_phd_addr, bus.inc_pfd_addr,
                     bus.phd_check_valid_ack, bus.pfd_check_valid_ack} == 6'd0);
          rst_n = 1'b1;
          fin = 1;
        end
      end
      if (!fin) begin @(posedge clk); #1; end
    end
    if (!fin) run_to = 1;
    bus.phd_check_valid = 1'b0; bus.pfd_check_valid = 1'b0; bus.done_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 0; bus.req_prefix_num = 0; bus.out_ready = 1; bus.done_ready = 0;
    bus.phd_check_valid = 0; bus.phd_crc_error = 0; bus.pfd_check_valid = 0; bus.pfd_crc_error = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    n_checks++; if ({bus.busy, bus.prefix_valid, bus.done_valid} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.prefix_valid, bus.done_valid}); end
    n_checks++; if ({bus.prefix_num, bus.done_status} !== 10'd0) begin n_errors++; $display("FAIL reset_regs: got %h want 0", {bus.prefix_num, bus.done_status}); end
    n_checks++; if ({bus.ld_phd_crc_addr, bus.ld_pfd_crc_addr, bus.inc_phd_addr, bus.inc_pfd_addr, bus.phd_check_valid_ack, bus.pfd_check_valid_ack} !== 6'd0) begin
      n_errors++; $display("FAIL reset_strobes: got %b want 000000", {bus.ld_phd_crc_addr, bus.ld_pfd_crc_addr, bus.inc_phd_addr, bus.inc_pfd_addr, bus.phd_check_valid_ack, bus.pfd_check_valid_ack}); end
  endtask

  task automatic test_nominal();
    int e_ld_pfd;
    run_fetch(6'd5, 3, 3, 0, 0, 0, 0, -1);
    e_ld_pfd = 4 + PHD_W + 3 + 1;
    n_checks++; if (!acc_rdy || run_to) begin n_errors++; $display("FAIL nom_run: got acc=%0b timeout=%0b want 1/0", acc_rdy, run_to); end
    n_checks++; if (c_ld_phd !== 1 || n_ld_phd !== 1) begin n_errors++; $display("FAIL nom_ld_phd: got cyc %0d n %0d want 1/1", c_ld_phd, n_ld_phd); end
    n_checks++; if (c_inc_first !== 4 || c_inc_last !== 3 + PHD_W || n_inc_phd !== PHD_W) begin
      n_errors++; $display("FAIL nom_inc_phd: got %0d..%0d n %0d want 4..%0d n %0d", c_inc_first, c_inc_last, n_inc_phd, 3 + PHD_W, PHD_W); end
    n_checks++; if (c_ld_pfd !== e_ld_pfd || n_ld_pfd !== 1) begin n_errors++; $display("FAIL nom_ld_pfd: got cyc %0d n %0d want %0d/1", c_ld_pfd, n_ld_pfd, e_ld_pfd); end
    n_checks++; if (c_ack_phd !== e_ld_pfd || n_ld_both !== 0) begin n_errors++; $display("FAIL nom_ack_overlap: got ack %0d both %0d want %0d/0", c_ack_phd, n_ld_both, e_ld_pfd); end
    n_checks++; if (n_inc_pfd !== PFD_W || pfd_start !== e_ld_pfd + 3 + PFD_W) begin n_errors++; $display("FAIL nom_inc_pfd: got n %0d end %0d want %0d/%0d", n_inc_pfd, pfd_start, PFD_W, e_ld_pfd + 3 + PFD_W); end
    n_checks++; if (c_done !== e_ld_pfd + 3 + PFD_W + 4 || st_done !== 4'b0000) begin n_errors++; $display("FAIL nom_done: got cyc %0d st %b want %0d/0000", c_done, st_done, e_ld_pfd + 3 + PFD_W + 4); end
    n_checks++; if (n_pv !== c_done - 1 || pnum_seen !== 6'd5 || !idle_ok) begin n_errors++; $display("FAIL nom_misc: got pv %0d pn %0d idle %0b want %0d/5/1", n_pv, pnum_seen, idle_ok, c_done - 1); end
  endtask

  task automatic test_ready_stall();
    int k, e_last;
    k = 0; e_last = -1;
    for (int c = 4; c < 100 && e_last < 0; c++) if (rdy_pat(c)) begin k++; if (k == PHD_W) e_last = c; end
    run_fetch(6'd9, 2, 1, 0, 0, 2, 0, -1);
    n_checks++; if (n_inc_phd !== PHD_W || n_bad_inc !== 0) begin n_errors++; $display("FAIL stall_inc: got n %0d bad %0d want %0d/0", n_inc_phd, n_bad_inc, PHD_W); end
    n_checks++; if (c_inc_first !== 4 || c_inc_last !== e_last || phd_start !== e_last + 1) begin
      n_errors++; $display("FAIL stall_timing: got %0d..%0d chk %0d want 4..%0d chk %0d", c_inc_first, c_inc_last, phd_start, e_last, e_last + 1); end
    n_checks++; if (n_inc_pfd !== PFD_W || st_done !== 4'b0000 || c_done !== pfd_start + 2) begin n_errors++; $display("FAIL stall_done: got n %0d st %b cyc %0d want %0d/0000/%0d", n_inc_pfd, st_done, c_done, PFD_W, pfd_start + 2); end
  endtask

  task automatic test_crc_errors();
    run_fetch(6'd33, 0, 5, 1, 1, 1, 3, -1);
    n_checks++; if (st_done !== 4'b0011 || run_to) begin n_errors++; $display("FAIL crc_status: got %b want 0011", st_done); end
    n_checks++; if (n_ack_phd !== 1 || n_ack_pfd !== 1) begin n_errors++; $display("FAIL crc_acks: got %0d/%0d want 1/1", n_ack_phd, n_ack_pfd); end
    n_checks++; if (n_inc_pfd !== PFD_W || c_ld_pfd !== phd_start + 1 || n_bad_inc !== 0) begin n_errors++; $display("FAIL crc_pfd: got n %0d ld %0d bad %0d want %0d/%0d/0", n_inc_pfd, c_ld_pfd, n_bad_inc, PFD_W, phd_start + 1); end
    n_checks++; if (n_done_hi !== 4 || n_stat_chg !== 0 || c_done !== pfd_start + 6) begin n_errors++; $display("FAIL crc_hold: got hi %0d chg %0d cyc %0d want 4/0/%0d", n_done_hi, n_stat_chg, c_done, pfd_start + 6); end
  endtask

  task automatic test_timeout();
    run_fetch(6'd7, -1, 0, 0, 0, 0, 0, -1);
    n_checks++; if (st_done !== 4'b0100 || c_done !== 4 + PHD_W + TMO) begin n_errors++; $display("FAIL tmo_phd: got st %b cyc %0d want 0100/%0d", st_done, c_done, 4 + PHD_W + TMO); end
    n_checks++; if (n_ack_phd !== 1 || c_ack_phd !== c_done || n_ld_pfd !== 0 || n_inc_pfd !== 0) begin
      n_errors++; $display("FAIL tmo_phd_side: got ack %0d@%0d ld_pfd %0d inc_pfd %0d want 1@%0d/0/0", n_ack_phd, c_ack_phd, n_ld_pfd, n_inc_pfd, c_done); end
    n_checks++; if (n_pv !== c_done - 1 || !idle_ok) begin n_errors++; $display("FAIL tmo_phd_pv: got %0d idle %0b want %0d/1", n_pv, idle_ok, c_done - 1); end
    run_fetch(6'd11, TMO - 1, TMO - 1, 0, 1, 0, 0, -1);
    n_checks++; if (st_done !== 4'b0010 || c_ld_pfd !== 4 + PHD_W + TMO) begin n_errors++; $display("FAIL tmo_edge: got st %b ld_pfd %0d want 0010/%0d", st_done, c_ld_pfd, 4 + PHD_W + TMO); end
    run_fetch(6'd12, 1, -1, 1, 0, 0, 0, -1);
    n_checks++; if (st_done !== 4'b0101 || c_done !== pfd_start + TMO || n_ack_pfd !== 1) begin
      n_errors++; $display("FAIL tmo_pfd: got st %b cyc %0d ack %0d want 0101/%0d/1", st_done, c_done, n_ack_pfd, pfd_start + TMO); end
  endtask

  task automatic test_bad_prefix();
    run_fetch(6'd0, 0, 0, 0, 0, 0, 20, -1);
    n_checks++; if (st_done !== 4'b1000 || c_done !== 1) begin n_errors++; $display("FAIL bad_pn_status: got %b@%0d want 1000@1", st_done, c_done); end
    n_checks++; if (n_ld_phd + n_ld_pfd + n_inc_phd + n_inc_pfd + n_ack_phd + n_ack_pfd + n_pv !== 0) begin
      n_errors++; $display("FAIL bad_pn_strobes: got %0d want 0", n_ld_phd + n_ld_pfd + n_inc_phd + n_inc_pfd + n_ack_phd + n_ack_pfd + n_pv); end
    n_checks++; if (n_done_hi !== 21 || n_stat_chg !== 0 || !idle_ok) begin n_errors++; $display("FAIL bad_pn_hold: got hi %0d chg %0d idle %0b want 21/0/1", n_done_hi, n_stat_chg, idle_ok); end
  endtask

  task automatic test_reset_mid();
    run_fetch(6'd21, 2, 2, 0, 0, 0, 0, 10);
    n_checks++; if (!rst_ok || c_done !== -1 || n_ack_pfd !== 0) begin n_errors++; $display("FAIL rst_mid: got ok %0b done %0d ack %0d want 1/-1/0", rst_ok, c_done, n_ack_pfd); end
    run_fetch(6'd22, 1, 4, 0, 1, 1, 0, -1);
    n_checks++; if (st_done !== 4'b0010 || !idle_ok || !acc_rdy || n_inc_pfd !== PFD_W) begin
      n_errors++; $display("FAIL rst_recover: got st %b idle %0b acc %0b n %0d want 0010/1/1/%0d", st_done, idle_ok, acc_rdy, n_inc_pfd, PFD_W); end
  endtask

  task automatic test_back_to_back();
    run_fetch(6'd40, 0, 0, 1, 0, 0, 0, -1);
    n_checks++; if (st_done !== 4'b0001 || !idle_ok) begin n_errors++; $display("FAIL b2b_first: got %b idle %0b want 0001/1", st_done, idle_ok); end
    run_fetch(6'd63, 0, 0, 0, 0, 0, 0, -1);
    n_checks++; if (!acc_rdy || st_done !== 4'b0000 || c_ld_phd !== 1 || pnum_seen !== 6'd63) begin
      n_errors++; $display("FAIL b2b_second: got acc %0b st %b ld %0d pn %0d want 1/0000/1/63", acc_rdy, st_done, c_ld_phd, pnum_seen); end
  endtask

  task automatic test_random();
    logic [5:0] pn; int pd, fd; bit pe, fe; logic [3:0] es; int ed;
    for (int it = 0; it < 10; it++) begin
      pn = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      pd = $urandom_range(0, 11); if (pd == 11) pd = -1;
      fd = $urandom_range(0, 11); if (fd == 11) fd = -1;
      pe = 1'($urandom); fe = 1'($urandom);
      run_fetch(pn, pd, fd, pe, fe, 1, $urandom_range(0, 3), -1);
      es = exp_status(pn, pd, fd, pe, fe);
      ed = exp_done(pn, pd, fd, phd_start, pfd_start);
      n_checks++; if (st_done !== es || c_done !== ed || run_to) begin
        n_errors++; $display("FAIL rnd%0d_done: pn %0d pd %0d fd %0d got %b@%0d want %b@%0d", it, pn, pd, fd, st_done, c_done, es, ed); end
      n_checks++; if (n_inc_phd !== ((pn == 0) ? 0 : PHD_W) || n_inc_pfd !== ((pn == 0 || tmo_hit(pd)) ? 0 : PFD_W) || n_bad_inc !== 0) begin
        n_errors++; $display("FAIL rnd%0d_incs: got %0d/%0d bad %0d", it, n_inc_phd, n_inc_pfd, n_bad_inc); end
      n_checks++; if (n_ack_phd !== ((pn == 0) ? 0 : 1) || n_ack_pfd !== ((pn == 0 || tmo_hit(pd)) ? 0 : 1) || n_ld_both !== 0) begin
        n_errors++; $display("FAIL rnd%0d_acks: got %0d/%0d both %0d", it, n_ack_phd, n_ack_pfd, n_ld_both); end
      n_checks++; if (pnum_seen !== pn || n_pv !== ((pn == 0) ? 0 : ed - 1) || !idle_ok || !acc_rdy || n_stat_chg !== 0) begin
        n_errors++; $display("FAIL rnd%0d_misc: got pn %0d pv %0d idle %0b acc %0b chg %0d want %0d/%0d", it, pnum_seen, n_pv, idle_ok, acc_rdy, n_stat_chg, pn, (pn == 0) ? 0 : ed - 1); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_ready_stall();
    test_crc_errors();
    test_timeout();
    test_bad_prefix();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
